// File: rtl/sd_cmd_framer.sv
// sd_cmd_framer: assembles SPI receiver bytes into 6-byte SD-style command
// frames (index, 32-bit argument, CRC7, end bit) and strobes the decoded
// fields for the command layer.
// Optional feature macro: CMD_CRC_CHECK_EN (CRC7 accumulator and compare).
// With the macro undefined no CRC logic exists and CrcOk reads 1 on every
// decoded frame.
module sd_cmd_framer #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CS,
    input  logic [7:0]  Buffer,
    input  logic        Changed,
    output logic        CmdValid,
    output logic [5:0]  CmdIndex,
    output logic [31:0] CmdArg,
    output logic        CrcOk,
    output logic        FrameErr,
    output logic        Busy
);

    localparam int unsigned TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned ARG_W   = 32;
    localparam int unsigned IDX_W   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARG  = 2'd1,
        CRC  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               changed_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ARG_W-1:0]   arg_q, arg_d;

    logic               valid_d;
    logic               ferr_d;
    logic               busy_d;
    logic [IDX_W-1:0]   cmd_index_d;
    logic [ARG_W-1:0]   cmd_arg_d;
    logic               crc_ok_d;

    logic               bv;
    logic               timer_exp;

`ifdef CMD_CRC_CHECK_EN
    logic [6:0]         crc_q, crc_d;

    // CRC7 (x^7 + x^3 + 1), one byte MSB first
    function automatic logic [6:0] crc7_upd(input logic [6:0] c, input logic [7:0] b);
        logic [6:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[6] ^ b[i];
            r  = {r[5:0], 1'b0};
            if (fb) r = r ^ 7'h09;
        end
        return r;
    endfunction
`endif

    // New byte is flagged by the rising edge of Changed
    assign bv        = Changed & ~changed_d;
    assign timer_exp = (timer_q == TW'(TIMEOUT - 1));

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            changed_d <= 1'b0;
            cnt_q     <= '0;
            timer_q   <= '0;
            idx_q     <= '0;
            arg_q     <= '0;
            CmdValid  <= 1'b0;
            CmdIndex  <= '0;
            CmdArg    <= '0;
            CrcOk     <= 1'b0;
            FrameErr  <= 1'b0;
            Busy      <= 1'b0;
`ifdef CMD_CRC_CHECK_EN
            crc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            changed_d <= Changed;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            arg_q     <= arg_d;
            CmdValid  <= valid_d;
            CmdIndex  <= cmd_index_d;
            CmdArg    <= cmd_arg_d;
            CrcOk     <= crc_ok_d;
            FrameErr  <= ferr_d;
            Busy      <= busy_d;
`ifdef CMD_CRC_CHECK_EN
            crc_q     <= crc_d;
`endif
        end
    end

    // Next-state, frame collection and strobe generation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        arg_d       = arg_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;
        cmd_index_d = CmdIndex;
        cmd_arg_d   = CmdArg;
        crc_ok_d    = CrcOk;
`ifdef CMD_CRC_CHECK_EN
        crc_d       = crc_q;
`endif

        if (CS) begin
            // Deselect drops the frame and any byte arriving with it
            state_d = IDLE;
            cnt_d   = '0;
            timer_d = '0;
`ifdef CMD_CRC_CHECK_EN
            crc_d   = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    timer_d = '0;
                    // Only a start byte (01xx_xxxx) opens a frame; fill bytes are ignored
                    if (bv && (Buffer[7:6] == 2'b01)) begin
                        idx_d   = Buffer[5:0];
                        cnt_d   = '0;
                        state_d = ARG;
`ifdef CMD_CRC_CHECK_EN
                        crc_d   = crc7_upd(7'd0, Buffer);
`endif
                    end
                end

                ARG: begin
                    if (bv) begin
                        arg_d   = {arg_q[23:0], Buffer};
                        cnt_d   = CNT_W'(cnt_q + 2'd1);
                        timer_d = '0;
`ifdef CMD_CRC_CHECK_EN
                        crc_d   = crc7_upd(crc_q, Buffer);
`endif
                        if (cnt_q == 2'd3) state_d = CRC;
                    end else if (timer_exp) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        timer_d = '0;
`ifdef CMD_CRC_CHECK_EN
                        crc_d   = '0;
`endif
                    end else begin
                        timer_d = TW'(timer_q + 1'b1);
                    end
                end

                CRC: begin
                    if (bv) begin
                        cmd_index_d = idx_q;
                        cmd_arg_d   = arg_q;
`ifdef CMD_CRC_CHECK_EN
                        crc_ok_d    = (Buffer[7:1] == crc_q);
                        crc_d       = '0;
`else
                        crc_ok_d    = 1'b1;
`endif
                        // End bit must be 1; otherwise report a framing error instead
                        if (Buffer[0]) valid_d = 1'b1;
                        else           ferr_d  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                        timer_d = '0;
                    end else if (timer_exp) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        timer_d = '0;
`ifdef CMD_CRC_CHECK_EN
                        crc_d   = '0;
`endif
                    end else begin
                        timer_d = TW'(timer_q + 1'b1);
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    timer_d = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_sd_cmd_framer.sv
// Directed bench for sd_cmd_framer: well-formed frames, CRC and end-bit
// errors, fill bytes, CS abort, inter-byte timeout and asynchronous reset.
module tb_sd_cmd_framer;

    localparam int unsigned TIMEOUT = 32;

    logic        CLK;
    logic        RST;
    logic        CS;
    logic [7:0]  Buffer;
    logic        Changed;
    logic        CmdValid;
    logic [5:0]  CmdIndex;
    logic [31:0] CmdArg;
    logic        CrcOk;
    logic        FrameErr;
    logic        Busy;

    int compared;
    int mismatched;

`ifdef CMD_CRC_CHECK_EN
    localparam logic BAD_CRC_OK = 1'b0;
`else
    localparam logic BAD_CRC_OK = 1'b1;
`endif

    sd_cmd_framer #(.TIMEOUT(TIMEOUT)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CS       (CS),
        .Buffer   (Buffer),
        .Changed  (Changed),
        .CmdValid (CmdValid),
        .CmdIndex (CmdIndex),
        .CmdArg   (CmdArg),
        .CrcOk    (CrcOk),
        .FrameErr (FrameErr),
        .Busy     (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach its end");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One byte: a low cycle, then Changed high across the accepting edge.
    // Returns 1 time unit after the edge that samples the byte strobe.
    task automatic send_byte(input logic [7:0] b);
        Changed = 1'b0;
        @(posedge CLK); #1;
        Buffer  = b;
        Changed = 1'b1;
        @(posedge CLK); #1;
        Changed = 1'b0;
    endtask

    task automatic send6(input logic [47:0] f);
        for (int i = 5; i >= 0; i--) send_byte(f[8*i +: 8]);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        RST     = 1'b1;
        CS      = 1'b0;
        Buffer  = 8'hFF;
        Changed = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_valid", 64'(CmdValid), 64'd0);
        check("rst_index", 64'(CmdIndex), 64'd0);
        check("rst_arg",   64'(CmdArg),   64'd0);
        check("rst_crcok", 64'(CrcOk),    64'd0);
        check("rst_ferr",  64'(FrameErr), 64'd0);
        check("rst_busy",  64'(Busy),     64'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // 1: CMD0 with its correct CRC
        send6(48'h40_00_00_00_00_95);
        check("t1_valid", 64'(CmdValid), 64'd1);
        check("t1_index", 64'(CmdIndex), 64'd0);
        check("t1_arg",   64'(CmdArg),   64'h0);
        check("t1_crcok", 64'(CrcOk),    64'd1);
        check("t1_ferr",  64'(FrameErr), 64'd0);
        check("t1_busy",  64'(Busy),     64'd0);
        @(posedge CLK); #1;
        check("t1_valid_clr", 64'(CmdValid), 64'd0);
        check("t1_crcok_hold", 64'(CrcOk),   64'd1);

        // 2: CMD8 0x1AA, then fill bytes and a CMD0
        send_byte(8'h48);
        check("t2_busy_mid", 64'(Busy), 64'd1);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA);
        check("t2_no_early_valid", 64'(CmdValid), 64'd0);
        send_byte(8'h87);
        check("t2_valid", 64'(CmdValid), 64'd1);
        check("t2_index", 64'(CmdIndex), 64'd8);
        check("t2_arg",   64'(CmdArg),   64'h0000_01AA);
        check("t2_crcok", 64'(CrcOk),    64'd1);
        send_byte(8'hFF);
        check("t2_ff_busy", 64'(Busy), 64'd0);
        check("t2_index_hold", 64'(CmdIndex), 64'd8);
        send_byte(8'hFF);
        check("t2_ff2_busy", 64'(Busy), 64'd0);
        send6(48'h40_00_00_00_00_95);
        check("t2b_valid", 64'(CmdValid), 64'd1);
        check("t2b_index", 64'(CmdIndex), 64'd0);
        check("t2b_arg",   64'(CmdArg),   64'h0);

        // 3: bad CRC, then bad end bit
        send6(48'h40_00_00_00_00_97);
        check("t3_valid", 64'(CmdValid), 64'd1);
        check("t3_crcok", 64'(CrcOk),    64'(BAD_CRC_OK));
        check("t3_ferr",  64'(FrameErr), 64'd0);
        @(posedge CLK); #1;
        check("t3_crcok_hold", 64'(CrcOk), 64'(BAD_CRC_OK));
        send6(48'h40_00_00_00_00_94);
        check("t3b_ferr",  64'(FrameErr), 64'd1);
        check("t3b_valid", 64'(CmdValid), 64'd0);
        check("t3b_busy",  64'(Busy),     64'd0);
        @(posedge CLK); #1;
        check("t3b_ferr_clr", 64'(FrameErr), 64'd0);

        // 4: CS abort mid-frame, then a clean CMD0
        send_byte(8'h48); send_byte(8'h00); send_byte(8'h00);
        check("t4_busy_pre", 64'(Busy), 64'd1);
        CS = 1'b1;
        @(posedge CLK); #1;
        check("t4_busy_abort",  64'(Busy),     64'd0);
        check("t4_valid_abort", 64'(CmdValid), 64'd0);
        check("t4_ferr_abort",  64'(FrameErr), 64'd0);
        @(posedge CLK); #1;
        CS = 1'b0;
        send6(48'h40_00_00_00_00_95);
        check("t4_valid", 64'(CmdValid), 64'd1);
        check("t4_index", 64'(CmdIndex), 64'd0);
        // Start byte arriving while deselected is dropped
        CS = 1'b1;
        send_byte(8'h40);
        check("t4_cs_drop_busy", 64'(Busy), 64'd0);
        CS = 1'b0;

        // 5: inter-byte timeout after the third byte
        send_byte(8'h51); send_byte(8'h00); send_byte(8'h00);
        repeat (TIMEOUT - 1) @(posedge CLK);
        #1;
        check("t5_busy_before_exp", 64'(Busy), 64'd1);
        @(posedge CLK); #1;
        check("t5_busy_exp",  64'(Busy),     64'd0);
        check("t5_valid_exp", 64'(CmdValid), 64'd0);
        check("t5_ferr_exp",  64'(FrameErr), 64'd0);
        // Variant: a byte strobe on the expiry edge keeps the frame alive
        send_byte(8'h51); send_byte(8'h00); send_byte(8'h00);
        repeat (TIMEOUT - 1) @(posedge CLK);
        #1;
        Buffer  = 8'h00;
        Changed = 1'b1;
        @(posedge CLK); #1;
        Changed = 1'b0;
        check("t5v_busy_kept", 64'(Busy), 64'd1);
        send_byte(8'h00);
        send_byte(8'h55);
        check("t5v_valid", 64'(CmdValid), 64'd1);
        check("t5v_index", 64'(CmdIndex), 64'd17);
        check("t5v_arg",   64'(CmdArg),   64'h0);

        // 6: asynchronous reset mid CMD8, remaining bytes must not decode
        send_byte(8'h48); send_byte(8'h00); send_byte(8'h00);
        #2 RST = 1'b1;
        #1;
        check("t6_rst_index", 64'(CmdIndex), 64'd0);
        check("t6_rst_arg",   64'(CmdArg),   64'd0);
        check("t6_rst_busy",  64'(Busy),     64'd0);
        check("t6_rst_crcok", 64'(CrcOk),    64'd0);
        #1 RST = 1'b0;
        send_byte(8'h01);
        check("t6_b3_valid", 64'(CmdValid), 64'd0);
        check("t6_b3_busy",  64'(Busy),     64'd0);
        send_byte(8'hAA);
        check("t6_b4_busy",  64'(Busy),     64'd0);
        send_byte(8'h87);
        check("t6_b5_valid", 64'(CmdValid), 64'd0);
        check("t6_b5_ferr",  64'(FrameErr), 64'd0);
        @(posedge CLK); #1;
        check("t6_after_valid", 64'(CmdValid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
